// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and shared types for the EX-stage ALU with
// iterative multiply/divide engine.
//   ALU_*       4-bit alu_ctrl operation codes
//   md_state_t  multiply/divide engine state
//   is_md_op()  true for codes that launch the multiply/divide engine
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SLL   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_XOR   = 4'b1001;
    localparam logic [3:0] ALU_MULT  = 4'b1010;
    localparam logic [3:0] ALU_MULTU = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_RSVD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/md_iter.sv
// md_iter: iterative multiply/divide engine. One shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle on operand magnitudes,
// followed by a sign-correction cycle.
//   clk_i, reset_i     clock, synchronous active-high reset
//   start_i            launch request (already qualified as a MD code)
//   op_i               alu_ctrl code (MULT/MULTU/DIV/DIVU)
//   a_i, b_i           operands
//   busy_o             engine occupied
//   wr_o               hi_o/lo_o hold the final value; HI/LO load this cycle
//   done_o             one-cycle pulse after the HI/LO load
//   hi_o, lo_o         sign-corrected result
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on accept
// RUN   | one iteration step per cycle, WIDTH cycles
// FIX   | sign-corrected result presented, HI/LO written at end of cycle
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             wr_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    // acc_q: product high half / partial remainder
    // opa_q: multiplier -> product low half / dividend -> quotient
    // opb_q: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, opa_q, opb_q;
    logic             is_div_q, neg_q, rem_neg_q, dz_q, done_q;

    logic             op_div, op_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_div    = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
        op_signed = (op_i == ALU_DIV) || (op_i == ALU_MULT);
        sa        = op_signed & a_i[WIDTH-1];
        sb        = op_signed & b_i[WIDTH-1];
        mag_a     = sa ? -a_i : a_i;
        mag_b     = sb ? -b_i : b_i;
    end

    logic [WIDTH:0]     mul_sum, rem_shift;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : '0);
        rem_shift = {acc_q, opa_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, opb_q};
        // when rem_ge holds the difference is below the divisor, so WIDTH bits suffice
        rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
        prod      = {acc_q, opa_q};
        prod_fix  = neg_q ? -prod : prod;
        if (is_div_q) begin
            hi_o = rem_neg_q ? -acc_q : acc_q;
            // divide by zero leaves the magnitude quotient all ones; force it
            // so the sign fix cannot turn it into 1
            lo_o = dz_q ? '1 : (neg_q ? -opa_q : opa_q);
        end else begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        acc_q     <= '0;
                        opa_q     <= mag_a;
                        opb_q     <= mag_b;
                        cnt_q     <= '0;
                        is_div_q  <= op_div;
                        neg_q     <= sa ^ sb;
                        rem_neg_q <= sa;
                        dz_q      <= op_div && (b_i == '0);
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (is_div_q) begin
                        acc_q <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                        opa_q <= {opa_q[WIDTH-2:0], rem_ge};
                    end else begin
                        acc_q <= mul_sum[WIDTH:1];
                        opa_q <= {mul_sum[0], opa_q[WIDTH-1:1]};
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign wr_o   = (state_q == FIX);
    assign done_o = done_q;

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: EX-stage ALU. Single-cycle logic/arith/shift ops are
// combinational; MULT/MULTU/DIV/DIVU run in md_iter and land in HI/LO.
//   clk_i, reset_i     clock, synchronous active-high reset
//   start_i            EX stage holds a live instruction
//   alu_ctrl_i         operation code (alu_pkg::ALU_*)
//   a_i, b_i           operands; shift amount is b_i[SHW-1:0]
//   result_o           single-cycle result (0 for MD and reserved codes)
//   zero_o             result_o == 0
//   overflow_o         signed overflow for ADD/SUB
//   busy_o             multiply/divide engine occupied
//   done_o             one-cycle pulse: HI/LO just updated
//   hi_o, lo_o         HI/LO architectural registers
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum, diff, res;
    logic             ovf;

    always_comb begin
        shamt = b_i[SHW-1:0];
        sum   = a_i + b_i;
        diff  = a_i - b_i;
        res   = '0;
        ovf   = 1'b0;
        case (alu_ctrl_i)
            ALU_AND:  res = a_i & b_i;
            ALU_OR:   res = a_i | b_i;
            ALU_ADD: begin
                res = sum;
                ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SLL:  res = a_i << shamt;
            ALU_SRL:  res = a_i >> shamt;
            ALU_SRA:  res = $signed(a_i) >>> shamt;
            ALU_SUB: begin
                res = diff;
                ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  res = a_i ^ b_i;
            ALU_NOR:  res = ~(a_i | b_i);
            default:  res = '0;
        endcase
    end

    assign result_o   = res;
    assign zero_o     = (res == '0);
    assign overflow_o = ovf;

    logic             md_start, md_wr;
    logic [WIDTH-1:0] md_hi, md_lo;

    // md_iter ignores start while busy, so no extra gating is needed here
    assign md_start = start_i && is_md_op(alu_ctrl_i);

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (md_start),
        .op_i    (alu_ctrl_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .wr_o    (md_wr),
        .done_o  (done_o),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        hi_d = md_wr ? md_hi : hi_q;
        lo_d = md_wr ? md_lo : lo_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
module tb_alu_md_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, ovf, busy, done;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] last_md = 64'h0;

    alu_md_unit #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .alu_ctrl_i (ctrl),
        .a_i        (a),
        .b_i        (b),
        .result_o   (result),
        .zero_o     (zero),
        .overflow_o (ovf),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hB) || (op == 4'hD) || (op == 4'hE);
    endfunction

    // {overflow, result} from plain integer arithmetic
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, t;
        logic [31:0] r;
        logic        v;
        int unsigned sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = y % 32;
        r  = 32'h0;
        v  = 1'b0;
        case (op)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: begin t = sx + sy; r = t[31:0]; v = (t != longint'($signed(r))); end
            4'h3: r = x << sh;
            4'h4: r = x >> sh;
            4'h5: begin t = sx >>> sh; r = t[31:0]; end
            4'h6: begin t = sx - sy; r = t[31:0]; v = (t != longint'($signed(r))); end
            4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
            4'h8: r = (x < y) ? 32'd1 : 32'd0;
            4'h9: r = x ^ y;
            4'hC: r = ~(x | y);
            default: r = 32'h0;
        endcase
        return {v, r};
    endfunction

    // {hi, lo} for the multiply/divide codes
    function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        logic [63:0] u;
        int          ix, iy, q, rm;
        ix = x;
        iy = y;
        case (op)
            4'hA: begin p = longint'(ix) * longint'(iy); return p; end
            4'hB: begin u = {32'h0, x}; u = u * {32'h0, y}; return u; end
            4'hD: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q  = ix / iy;
                rm = ix % iy;
                return {rm, q};
            end
            4'hE: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            4: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    task automatic alu_const(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] er, input logic ev, input logic ez);
        ctrl = op; a = x; b = y;
        @(negedge clk);
        check({tag, " result"}, result, er);
        check({tag, " overflow"}, ovf, ev);
        check({tag, " zero"}, zero, ez);
    endtask

    task automatic alu_rand(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] e;
        ctrl = op; a = x; b = y;
        e = alu_ref(op, x, y);
        @(negedge clk);
        check($sformatf("rnd op%0h %h,%h result", op, x, y), result, e[31:0]);
        check($sformatf("rnd op%0h %h,%h overflow", op, x, y), ovf, e[32]);
        check($sformatf("rnd op%0h %h,%h zero", op, x, y), zero, (e[31:0] == 32'h0));
    endtask

    // Issues one MD op in the current cycle and follows it to its done cycle.
    task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp);
        int nb;
        bit early;
        ctrl = op; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        early = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (busy === 1'b1) nb++;
            if (done === 1'b1) early = 1'b1;
            if (k > 0) check({tag, " hi held while busy"}, {hi, lo}, last_md);
            tick();
        end
        check({tag, " busy cycles"}, nb, 33);
        check({tag, " early done"}, early, 0);
        check({tag, " done"}, done, 1);
        check({tag, " busy after"}, busy, 0);
        check({tag, " hi"}, hi, exp[63:32]);
        check({tag, " lo"}, lo, exp[31:0]);
        last_md = exp;
    endtask

    initial begin
        int          nb, nd;
        bit          early;
        logic [3:0]  op;
        logic [31:0] x, y;
        logic [63:0] e;

        reset = 1'b1; start = 1'b0; ctrl = 4'h0; a = 32'h0; b = 32'h0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b0;

        alu_const("add ovf",   4'h2, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1'b1, 1'b0);
        alu_const("sub zero",  4'h6, 32'd5,         32'd5,        32'h0,         1'b0, 1'b1);
        alu_const("slt",       4'h7, 32'hFFFF_FFFF, 32'h1,        32'h1,         1'b0, 1'b0);
        alu_const("sltu",      4'h8, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1'b1);
        alu_const("sra",       4'h5, 32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0, 1'b0);
        alu_const("sll b33",   4'h3, 32'h1234_5678, 32'd33,       32'h2468_ACF0, 1'b0, 1'b0);
        alu_const("sub ovf",   4'h6, 32'h8000_0000, 32'h1,        32'h7FFF_FFFF, 1'b1, 1'b0);
        alu_const("add wrap",  4'h2, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b0, 1'b1);
        alu_const("nor",       4'hC, 32'h0,         32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0);
        alu_const("mult code", 4'hA, 32'h5,         32'h3,        32'h0,         1'b0, 1'b1);
        alu_const("reserved",  4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            start = is_md(op) ? 1'b0 : 1'($urandom_range(0, 1));
            alu_rand(op, pick(), pick());
        end
        start = 1'b0;
        @(negedge clk);
        check("no stray busy", busy, 0);

        md_op("mult -3*5",     4'hA, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1);
        md_op("div 7/-2",      4'hD, 32'd7,         32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
        md_op("divu 9/0",      4'hE, 32'd9,         32'h0,        {32'd9, 32'hFFFF_FFFF});
        md_op("div minneg/-1", 4'hD, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        md_op("div -7/0",      4'hD, 32'hFFFF_FFF9, 32'h0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        md_op("multu max",     4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        md_op("mult minneg^2", 4'hA, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        check("b2b done present", done, 1);
        md_op("b2b divu", 4'hE, 32'd100, 32'd7, {32'd2, 32'd14});
        tick();
        check("done single pulse", done, 0);
        check("hi held after done", {hi, lo}, last_md);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: op = 4'hA;
                1: op = 4'hB;
                2: op = 4'hD;
                default: op = 4'hE;
            endcase
            x = pick();
            y = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
            md_op($sformatf("rnd md op%0h %h,%h", op, x, y), op, x, y, md_ref(op, x, y));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // second start while busy is ignored; single-cycle path stays live
        x = 32'h1234_5678; y = 32'h9ABC_DEF0;
        e = md_ref(4'hB, x, y);
        ctrl = 4'hB; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        ctrl = 4'h9; a = 32'hF0F0_1234; b = 32'h0FF0_4321;
        #1;
        check("xor while busy", result, 32'hFF00_5115);
        tick(); tick(); tick(); tick();
        check("busy at T+5", busy, 1);
        check("old hi/lo at T+5", {hi, lo}, last_md);
        ctrl = 4'hE; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (done === 1'b1) early = 1'b1;
            tick();
        end
        check("ignored start early done", early, 0);
        check("ignored start done", done, 1);
        check("ignored start hi", hi, e[63:32]);
        check("ignored start lo", lo, e[31:0]);
        last_md = e;

        // reset mid-operation aborts and clears HI/LO
        ctrl = 4'hB; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("busy before abort", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        nb = 0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b1) nb++;
            if (done === 1'b1) nd++;
            tick();
        end
        check("abort no busy later", nb, 0);
        check("abort no done later", nd, 0);
        last_md = 64'h0;

        md_op("post-reset mult", 4'hA, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
